change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 137 +++++++++++++
 tb/tb_change_dispenser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount back as quarter/dime/nickel pulses,
// one coin per clock, greedy largest-coin-first, limited by per-coin inventory.
// Completion is flagged with a one-cycle Done; any undispensed residue is left
// in Rem with Short set until the next accepted Start or reset.
module change_dispenser #(
  parameter int INV_W  = 4,
  parameter int Q_INIT = 4,
  parameter int D_INIT = 4,
  parameter int N_INIT = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [5:0] Amount,
  input  logic       Refill,
  output logic       QOut,
  output logic       DOut,
  output logic       NOut,
  output logic       Busy,
  output logic       Done,
  output logic       Short,
  output logic [5:0] Rem
);

  typedef enum logic {
    IDLE,
    DISPENSE
  } state_t;

  localparam logic [INV_W-1:0] QINV_INIT = INV_W'(Q_INIT);
  localparam logic [INV_W-1:0] DINV_INIT = INV_W'(D_INIT);
  localparam logic [INV_W-1:0] NINV_INIT = INV_W'(N_INIT);
  localparam logic [INV_W-1:0] INV_ONE   = INV_W'(1);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_rem, w_rem_nxt;
  logic [INV_W-1:0] r_qinv, w_qinv_nxt;
  logic [INV_W-1:0] r_dinv, w_dinv_nxt;
  logic [INV_W-1:0] r_ninv, w_ninv_nxt;
  logic             r_qout, w_qout_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_nout, w_nout_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_short, w_short_nxt;

  // State, residue, inventory and output registers; reset aborts any transaction.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_qinv  <= QINV_INIT;
      r_dinv  <= DINV_INIT;
      r_ninv  <= NINV_INIT;
      r_qout  <= 1'b0;
      r_dout  <= 1'b0;
      r_nout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_qinv  <= w_qinv_nxt;
      r_dinv  <= w_dinv_nxt;
      r_ninv  <= w_ninv_nxt;
      r_qout  <= w_qout_nxt;
      r_dout  <= w_dout_nxt;
      r_nout  <= w_nout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_short <= w_short_nxt;
    end
  end

  // Next-state logic: accept requests in IDLE, issue one greedy coin per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_qinv_nxt  = r_qinv;
    w_dinv_nxt  = r_dinv;
    w_ninv_nxt  = r_ninv;
    w_qout_nxt  = 1'b0;
    w_dout_nxt  = 1'b0;
    w_nout_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_short_nxt = r_short;
    case (r_state)
      IDLE: begin
        // Refill and Start in the same cycle: the reload is in place before
        // the first coin decision, which happens one edge later.
        if (Refill) begin
          w_qinv_nxt = QINV_INIT;
          w_dinv_nxt = DINV_INIT;
          w_ninv_nxt = NINV_INIT;
        end
        if (Start) begin
          w_rem_nxt   = Amount;
          w_busy_nxt  = 1'b1;
          w_short_nxt = 1'b0;
          w_state_nxt = DISPENSE;
        end
      end
      DISPENSE: begin
        if (r_rem >= 6'd25 && r_qinv != '0) begin
          w_qout_nxt = 1'b1;
          w_rem_nxt  = r_rem - 6'd25;
          w_qinv_nxt = r_qinv - INV_ONE;
        end else if (r_rem >= 6'd10 && r_dinv != '0) begin
          w_dout_nxt = 1'b1;
          w_rem_nxt  = r_rem - 6'd10;
          w_dinv_nxt = r_dinv - INV_ONE;
        end else if (r_rem >= 6'd5 && r_ninv != '0) begin
          w_nout_nxt = 1'b1;
          w_rem_nxt  = r_rem - 6'd5;
          w_ninv_nxt = r_ninv - INV_ONE;
        end else begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_short_nxt = (r_rem != '0);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign QOut  = r_qout;
  assign DOut  = r_dout;
  assign NOut  = r_nout;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Short = r_short;
  assign Rem   = r_rem;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: table of directed transactions, hand-written
// corner sequences (busy-time requests, async reset) and random transactions
// checked against a count-based greedy reference model.
module tb_change_dispenser;

  localparam int INIT = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic [5:0] Amount = '0;
  logic       Refill = 1'b0;
  logic       QOut, DOut, NOut, Busy, Done, Short;
  logic [5:0] Rem;

  int n_checks = 0;
  int n_fail   = 0;
  int mq = INIT, md = INIT, mn = INIT;

  change_dispenser #(.INV_W(4), .Q_INIT(INIT), .D_INIT(INIT), .N_INIT(INIT)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Amount(Amount), .Refill(Refill),
    .QOut(QOut), .DOut(DOut), .NOut(NOut), .Busy(Busy), .Done(Done),
    .Short(Short), .Rem(Rem)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy policy expressed as counts: each coin type takes as many as the
  // remaining amount and its inventory allow, largest first.
  function automatic void predict(input int amt, input int q, input int d, input int n,
                                  output int nq, output int nd, output int nn,
                                  output int sh, output int rem);
    int r;
    r   = amt;
    nq  = (r / 25 < q) ? r / 25 : q;  r -= 25 * nq;
    nd  = (r / 10 < d) ? r / 10 : d;  r -= 10 * nd;
    nn  = (r / 5  < n) ? r / 5  : n;  r -= 5 * nn;
    sh  = (r != 0);
    rem = r;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    mq = INIT; md = INIT; mn = INIT;
  endtask

  // rmode: 0 none, 1 Refill in a separate IDLE cycle, 2 Refill together with Start.
  // poke: drive Start+Refill during the first dispense cycles (must be ignored).
  task automatic run_txn(input string tag, input int amt, input int rmode, input int poke,
                         input int enq, input int end_, input int enn,
                         input int esh, input int erem);
    int exp_seq[$];
    int got_seq[$];
    int cyc;
    int ncoin;
    bit seen_done;
    if (rmode != 0) begin mq = INIT; md = INIT; mn = INIT; end
    if (rmode == 1) begin
      @(negedge Clk); Refill = 1'b1;
      @(negedge Clk); Refill = 1'b0;
    end
    @(negedge Clk);
    Start = 1'b1; Amount = 6'(amt); Refill = (rmode == 2);
    @(negedge Clk);
    Start = 1'b0; Refill = 1'b0; Amount = 6'($urandom);
    chk({tag, "_busy_e0"}, int'(Busy), 1);
    chk({tag, "_coin_e0"}, int'({QOut, DOut, NOut}), 0);
    chk({tag, "_short_e0"}, int'(Short), 0);
    for (int i = 0; i < enq; i++) exp_seq.push_back(1);
    for (int i = 0; i < end_; i++) exp_seq.push_back(2);
    for (int i = 0; i < enn; i++) exp_seq.push_back(3);
    ncoin = enq + end_ + enn;
    cyc = 0;
    seen_done = 0;
    while (!seen_done && cyc < 80) begin
      @(negedge Clk);
      cyc++;
      chk({tag, "_onehot"}, int'($countones({QOut, DOut, NOut}) <= 1), 1);
      if (Done) seen_done = 1;
      else begin
        got_seq.push_back(QOut ? 1 : DOut ? 2 : NOut ? 3 : 0);
        if (!Busy) chk({tag, "_busy_mid"}, int'(Busy), 1);
      end
      if (poke != 0 && cyc == 1) begin Start = 1'b1; Refill = 1'b1; Amount = 6'd25; end
      if (poke != 0 && cyc == 2) begin Start = 1'b0; Refill = 1'b0; end
    end
    Start = 1'b0; Refill = 1'b0;
    chk({tag, "_done_seen"}, int'(seen_done), 1);
    chk({tag, "_latency"}, cyc, ncoin + 1);
    chk({tag, "_ncoins"}, got_seq.size(), ncoin);
    for (int i = 0; i < got_seq.size() && i < ncoin; i++)
      chk({tag, "_coin"}, got_seq[i], exp_seq[i]);
    chk({tag, "_busy_end"}, int'(Busy), 0);
    chk({tag, "_short"}, int'(Short), esh);
    chk({tag, "_rem"}, int'(Rem), erem);
    @(negedge Clk);
    chk({tag, "_done_1cyc"}, int'(Done), 0);
    chk({tag, "_idle_busy"}, int'(Busy), 0);
    chk({tag, "_short_hold"}, int'(Short), esh);
    chk({tag, "_rem_hold"}, int'(Rem), erem);
    mq -= enq; md -= end_; mn -= enn;
  endtask

  task automatic model_txn(input string tag, input int amt, input int rmode, input int poke);
    int nq, nd, nn, sh, rem;
    if (rmode != 0) predict(amt, INIT, INIT, INIT, nq, nd, nn, sh, rem);
    else            predict(amt, mq, md, mn, nq, nd, nn, sh, rem);
    run_txn(tag, amt, rmode, poke, nq, nd, nn, sh, rem);
  endtask

  typedef struct {
    int rst_before;
    int rmode;
    int amt;
    int nq, nd, nn, sh, rem;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 0, 40, 1, 1, 1, 0, 0};
    tbl[1] = '{1, 0, 60, 2, 1, 0, 0, 0};
    tbl[2] = '{0, 0,  0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 63, 2, 1, 0, 1, 3};   // q 2->0 on this one
    tbl[4] = '{1, 0, 50, 2, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 50, 2, 0, 0, 0, 0};   // quarters exhausted
    tbl[6] = '{0, 0, 25, 0, 2, 1, 0, 0};   // d=2, n=3 left
    tbl[7] = '{0, 0, 50, 0, 2, 3, 1, 15};  // 50-20-15 = 15 owed
    tbl[8] = '{0, 1, 25, 1, 0, 0, 0, 0};   // refill in IDLE first
    tbl[9] = '{0, 2, 55, 2, 0, 1, 0, 0};   // refill with start after partial use

    // Reset state
    #12;
    chk("rst_coins", int'({QOut, DOut, NOut}), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_short", int'(Short), 0);
    chk("rst_rem", int'(Rem), 0);
    @(negedge Clk);
    Rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_before != 0) do_reset();
      run_txn($sformatf("tbl%0d", i), tbl[i].amt, tbl[i].rmode, 0,
              tbl[i].nq, tbl[i].nd, tbl[i].nn, tbl[i].sh, tbl[i].rem);
      if (i == 3) begin
        repeat (3) @(negedge Clk);
        chk("hold_short", int'(Short), 1);
        chk("hold_rem", int'(Rem), 3);
      end
    end

    // Start+Refill while busy are ignored: quarters stay exhausted afterwards
    do_reset();
    run_txn("dep1", 50, 0, 0, 2, 0, 0, 0, 0);
    run_txn("dep2", 50, 0, 0, 2, 0, 0, 0, 0);
    run_txn("poke", 40, 0, 1, 0, 4, 0, 0, 0);
    run_txn("after_poke", 25, 0, 0, 0, 0, 4, 1, 5);

    // Asynchronous reset after the first coin
    do_reset();
    run_txn("dep3", 50, 0, 0, 2, 0, 0, 0, 0);
    run_txn("dep4", 50, 0, 0, 2, 0, 0, 0, 0);
    @(negedge Clk); Start = 1'b1; Amount = 6'd40;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    chk("arst_first_coin", int'(DOut), 1);
    #2 Rst = 1'b1;
    #1;
    chk("arst_coins", int'({QOut, DOut, NOut}), 0);
    chk("arst_busy", int'(Busy), 0);
    chk("arst_done", int'(Done), 0);
    chk("arst_rem", int'(Rem), 0);
    @(negedge Clk); Rst = 1'b0;
    mq = INIT; md = INIT; mn = INIT;
    run_txn("arst_after", 25, 0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(negedge Clk);
    chk("arst_no_restart", int'(Busy), 0);

    // Random transactions against the reference model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) do_reset();
      model_txn($sformatf("rnd%0d", i), int'($urandom_range(0, 63)),
                (r == 1) ? 1 : (r == 2) ? 2 : 0, (r == 3) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
